// File: rtl/cordic_fixedpoint_input_sequencer_pkg.sv
// +----------------------------------------------------------------------------+
// | cordic_tb_pkg: shared widths and state encoding for the phase sequencer    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package cordic_tb_pkg;

  localparam int DEF_PHASE_W     = 24;
  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_NUM_VECTORS = 32;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH   = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT    = 3'd2;
  localparam logic [STATE_W-1:0] S_PRESENT = 3'd3;
  localparam logic [STATE_W-1:0] S_GAP     = 3'd4;
  localparam logic [STATE_W-1:0] S_DONE    = 3'd5;

endpackage

`default_nettype wire

// File: rtl/cordic_fixedpoint_input_sequencer_gap_counter.sv
// +----------------------------------------------------------------------------+
// | cordic_tb_gap_counter: loadable down-counter with a zero flag              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cordic_tb_gap_counter #(
  parameter int WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoad_val,
  input  logic             iDec,
  output logic             oZero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_count <= '0;
    end else if (iLoad) begin
      r_count <= iLoad_val;
    end else if (iDec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign oZero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/cordic_fixedpoint_input_sequencer.sv
// +----------------------------------------------------------------------------+
// | cordic_fixedpoint_input_sequencer: walks the phase ROM and hands each      |
// | angle to the CORDIC core over valid/ready. Rev 1.0                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module cordic_fixedpoint_input_sequencer
  import cordic_tb_pkg::*;
#(
  parameter int NUM_VECTORS = DEF_NUM_VECTORS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int PHASE_W     = DEF_PHASE_W,
  parameter int GAP_CYCLES  = 0
) (
  input  logic               iClk,
  input  logic               iRstn,
  input  logic               iStart,
  input  logic [PHASE_W-1:0] iPhase_rom,
  input  logic               iReady,
  output logic [ADDR_W-1:0]  oAddr_phase,
  output logic [PHASE_W-1:0] oPhase,
  output logic               oValid,
  output logic               oBusy,
  output logic               oDone,
  output logic [ADDR_W:0]    oCount
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int c_gap_load = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
  localparam logic [ADDR_W:0] c_last_count = (ADDR_W + 1)'(NUM_VECTORS - 1);

  logic [STATE_W-1:0] r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [PHASE_W-1:0] r_phase;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic [ADDR_W:0]    r_count;

  logic w_xfer;
  logic w_last;
  logic w_gap_load;
  logic w_gap_dec;
  logic w_gap_zero;

  assign w_xfer     = (r_state == S_PRESENT) && iReady;
  assign w_last     = (r_count == c_last_count);
  assign w_gap_load = w_xfer && !w_last && (GAP_CYCLES > 0);
  assign w_gap_dec  = (r_state == S_GAP);

  cordic_tb_gap_counter #(
    .WIDTH(GAP_W)
  ) u_gap_counter (
    .iClk     (iClk),
    .iRstn    (iRstn),
    .iLoad    (w_gap_load),
    .iLoad_val(GAP_W'(c_gap_load)),
    .iDec     (w_gap_dec),
    .oZero    (w_gap_zero)
  );

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_phase <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (iStart) begin
            r_state <= S_FETCH;
            r_addr  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        // ROM samples r_addr at this edge; its output is ready one cycle later
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          r_phase <= iPhase_rom;
          r_valid <= 1'b1;
          r_state <= S_PRESENT;
        end
        S_PRESENT: begin
          if (iReady) begin
            r_valid <= 1'b0;
            r_count <= r_count + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_FETCH;
              r_addr  <= r_addr + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (w_gap_zero) begin
            r_state <= S_FETCH;
            r_addr  <= r_addr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign oAddr_phase = r_addr;
  assign oPhase      = r_phase;
  assign oValid      = r_valid;
  assign oBusy       = r_busy;
  assign oDone       = r_done;
  assign oCount      = r_count;

endmodule

`default_nettype wire

// File: doc/cordic_fixedpoint_input_sequencer.md
Name: cordic_fixedpoint_input_sequencer

Overview:
Testbench-side stimulus sequencer sitting directly upstream of the input phase ROM and downstream of it toward the CORDIC core. It drives the ROM read address, captures each registered 24-bit initial angle, and presents it to the core with a valid/ready handshake. It steps through NUM_VECTORS entries with an optional inter-vector gap, then flags completion.

Parameters:
NUM_VECTORS, 32, number of ROM entries issued per run (1..2**ADDR_W)
ADDR_W, 5, ROM address width
PHASE_W, 24, phase word width
GAP_CYCLES, 0, idle cycles inserted after each accepted vector before the next fetch

Ports:
iClk  input  1  clock
iRstn  input  1  asynchronous active-low reset
iStart  input  1  start a run; sampled only in IDLE or DONE
iPhase_rom  input  PHASE_W  registered ROM data (1-cycle read latency)
iReady  input  1  core accepts oPhase this cycle
oAddr_phase  output  ADDR_W  ROM read address
oPhase  output  PHASE_W  phase word to core
oValid  output  1  oPhase valid
oBusy  output  1  run in progress (state not IDLE/DONE)
oDone  output  1  sticky run-complete flag
oCount  output  ADDR_W+1  number of vectors accepted this run

Behaviour:
- Reset (async, iRstn=0): state IDLE; oAddr_phase=0, oPhase=0, oValid=0, oBusy=0, oDone=0, oCount=0, gap counter=0. Reset mid-run aborts immediately; no partial transfer is completed.
- All outputs are registered.
- States: IDLE, FETCH, WAIT, PRESENT, GAP, DONE.
- IDLE/DONE: at edge with iStart=1 -> FETCH; oAddr_phase<=0, oCount<=0, oDone<=0.
- FETCH (1 cycle): oAddr_phase stable; ROM registers data at this edge -> WAIT.
- WAIT (1 cycle): at edge, oPhase<=iPhase_rom, oValid<=1 -> PRESENT. Result: oValid first high 3 edges after the iStart edge.
- PRESENT: oValid and oPhase held stable until iReady=1. Transfer occurs at the edge with oValid&&iReady. At that edge: oValid<=0, oCount<=oCount+1; if oCount==NUM_VECTORS-1 -> DONE with oDone<=1; else if GAP_CYCLES>0 -> GAP with counter<=GAP_CYCLES-1; else -> FETCH with oAddr_phase<=oAddr_phase+1.
- GAP: counter decrements each cycle. When counter==0, at the edge -> FETCH with oAddr_phase<=oAddr_phase+1.
- Back-to-back (GAP_CYCLES=0, iReady tied 1): one vector per 3 cycles.
- iStart while busy is ignored.
- In DONE, oDone stays 1 until a new iStart. iStart in DONE restarts the run: oDone clears at that edge.
- Address wrap: oAddr_phase never exceeds NUM_VECTORS-1. With NUM_VECTORS=2**ADDR_W, the last address is all-ones and is not incremented.
- iReady while oValid=0 has no effect.
- oPhase keeps the last presented value after transfer, until the next WAIT capture.

Decomposition:
- Shared package (cordic_tb_pkg): PHASE_W, ADDR_W, NUM_VECTORS defaults; state enum encoding (IDLE, FETCH, WAIT, PRESENT, GAP, DONE).
- Sub-module: the gap down-counter, cordic_tb_gap_counter (load/decrement/zero flag). Everything else is flat.

Test Plan:
- Basic run: ROM loaded with 32'h... entries 0x000001..0x000020, iReady=1, GAP_CYCLES=0, pulse iStart -> oValid pulses 32 times, oPhase sequence 0x000001..0x000020, first oValid 3 edges after iStart, 3-cycle spacing, then oDone=1 and oCount=32.
- Backpressure: iReady=0 for 5 cycles on vector 4 -> oValid and oPhase (0x000005) held stable for all 5 cycles; transfer on the first iReady=1 edge; oAddr_phase does not advance early.
- Gap: GAP_CYCLES=3 -> exactly 3 idle cycles between a transfer edge and the next FETCH; spacing becomes 6 cycles.
- Reset mid-run: assert iRstn=0 asynchronously during PRESENT of vector 10 -> outputs go to 0 without waiting for a clock edge; a subsequent iStart restarts from address 0.
- Start ignored/restart: pulse iStart during PRESENT -> no effect on the sequence. Pulse iStart in DONE -> oDone clears at that edge and the run repeats from address 0.
- Short run: NUM_VECTORS=1 -> exactly one vector (address 0), then DONE with oCount=1.
